// File: rtl/c3aibadapt_rxdp_pkg.sv
// ---------------------------------------------------------------------------
// c3aibadapt_rxdp_pkg
// Shared definitions for the RX datapath-map mode sequencer:
//   - datapath map mode codes (OFF, EHIP, ELANE, RSFEC, PMADIR)
//   - sequencer state encoding
//   - phase counter width and helpers for counter load values / mode checks
// ---------------------------------------------------------------------------
package c3aibadapt_rxdp_pkg;

    localparam int CNT_W = 8;

    localparam logic [2:0] MODE_OFF    = 3'd0;
    localparam logic [2:0] MODE_EHIP   = 3'd1;
    localparam logic [2:0] MODE_ELANE  = 3'd2;
    localparam logic [2:0] MODE_RSFEC  = 3'd3;
    localparam logic [2:0] MODE_PMADIR = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HOLD   = 3'd1,
        ST_RST    = 3'd2,
        ST_SWITCH = 3'd3,
        ST_SETTLE = 3'd4,
        ST_DONE   = 3'd5
    } seq_state_e;

    // Codes above PMA-direct are reserved and must be rejected.
    function automatic logic mode_is_valid(input logic [2:0] mode);
        return (mode <= MODE_PMADIR);
    endfunction

    // A phase of N cycles loads N-1 so that the phase exits on the cycle the
    // counter reads zero.
    function automatic logic [CNT_W-1:0] cnt_load_val(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/c3aibadapt_rxdp_seq_cnt.sv
// ---------------------------------------------------------------------------
// c3aibadapt_rxdp_seq_cnt
// Loadable saturating down-counter used to time sequencer phases.
// Ports:
//   clk       - counter clock
//   rst       - asynchronous active-high reset (counter clears to zero)
//   load      - load load_val this cycle (has priority over counting)
//   load_val  - value to load (N-1 for an N-cycle phase)
//   expired   - counter currently reads zero
// The counter stops at zero rather than wrapping, so a phase that waits on an
// external condition after expiry keeps seeing expired = 1.
// ---------------------------------------------------------------------------
module c3aibadapt_rxdp_seq_cnt
    import c3aibadapt_rxdp_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt_r;

    // Down-count with load priority, saturating at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != {W{1'b0}}) begin
            cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/c3aibadapt_rxdp_mode_seq.sv
// ---------------------------------------------------------------------------
// c3aibadapt_rxdp_mode_seq
// Owns the RX datapath-map configuration (dp_map_mode, dp_wm_en) and changes
// it safely: hold FIFO writes, drain, pulse the capture-register reset,
// commit the new mode, settle, then acknowledge with cfg_done.
//
// Optional feature macro: C3AIBADAPT_RXDP_SEQ_TIMEOUT_EN
//   defined   - HOLD gives up after TIMEOUT_CYCLES, sets err_drain_to, continues
//   undefined - HOLD waits for fifo_empty indefinitely, err_drain_to tied to 0
//
// Ports:
//   rx_clock_fifo_wr_clk  - sole clock (RX FIFO write clock)
//   rx_reset_fifo_wr_rst  - asynchronous active-high reset
//   cfg_req_valid/ready   - mode-change request handshake (ready = IDLE)
//   cfg_mode_req          - requested mode (000 off .. 100 PMA-direct)
//   cfg_wm_en_req         - requested word-marker enable
//   cfg_done              - one-cycle completion pulse
//   fifo_empty            - RX FIFO drained indication
//   dp_map_mode, dp_wm_en - committed configuration
//   dp_wr_hold            - blocks RX FIFO writes during a change
//   dp_path_rst           - reset to datapath capture registers
//   seq_busy              - sequencer not IDLE
//   err_bad_mode          - sticky, request with reserved mode rejected
//   err_drain_to          - sticky, HOLD drain timed out
//   err_clr               - clears both sticky errors (wins over a set)
// ---------------------------------------------------------------------------
module c3aibadapt_rxdp_mode_seq
    import c3aibadapt_rxdp_pkg::*;
#(
    parameter int DRAIN_CYCLES   = 8,
    parameter int RST_CYCLES     = 2,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       rx_clock_fifo_wr_clk,
    input  logic       rx_reset_fifo_wr_rst,
    input  logic       cfg_req_valid,
    output logic       cfg_req_ready,
    input  logic [2:0] cfg_mode_req,
    input  logic       cfg_wm_en_req,
    output logic       cfg_done,
    input  logic       fifo_empty,
    output logic [2:0] dp_map_mode,
    output logic       dp_wm_en,
    output logic       dp_wr_hold,
    output logic       dp_path_rst,
    output logic       seq_busy,
    output logic       err_bad_mode,
    output logic       err_drain_to,
    input  logic       err_clr
);

    localparam logic [CNT_W-1:0] DRAIN_LD  = cnt_load_val(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] RST_LD    = cnt_load_val(RST_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LD = cnt_load_val(SETTLE_CYCLES);

    seq_state_e       state_r;
    seq_state_e       state_nxt_s;
    logic             accept_s;
    logic             bad_mode_set_s;
    logic             cnt_load_s;
    logic [CNT_W-1:0] cnt_load_val_s;
    logic             cnt_expired_s;

    logic [2:0]       mode_q_r;
    logic             wm_q_r;
    logic [2:0]       dp_map_mode_r;
    logic             dp_wm_en_r;
    logic             dp_wr_hold_r;
    logic             dp_path_rst_r;
    logic             cfg_done_r;
    logic             seq_busy_r;
    logic             err_bad_mode_r;

`ifdef C3AIBADAPT_RXDP_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LD = cnt_load_val(TIMEOUT_CYCLES);

    logic             to_load_s;
    logic             to_expired_s;
    logic             drain_to_set_s;
    logic             err_drain_to_r;
`endif

    // Ready is decoded straight from the state so a request can be taken on
    // the first IDLE cycle.
    assign cfg_req_ready = (state_r == ST_IDLE);
    assign accept_s      = cfg_req_valid & cfg_req_ready;

    // Shared phase timer for HOLD minimum, RST pulse width and SETTLE time.
    c3aibadapt_rxdp_seq_cnt #(
        .W        (CNT_W)
    ) u_phase_cnt (
        .clk      (rx_clock_fifo_wr_clk),
        .rst      (rx_reset_fifo_wr_rst),
        .load     (cnt_load_s),
        .load_val (cnt_load_val_s),
        .expired  (cnt_expired_s)
    );

`ifdef C3AIBADAPT_RXDP_SEQ_TIMEOUT_EN
    // Drain watchdog, started together with HOLD and counting total HOLD time.
    c3aibadapt_rxdp_seq_cnt #(
        .W        (CNT_W)
    ) u_timeout_cnt (
        .clk      (rx_clock_fifo_wr_clk),
        .rst      (rx_reset_fifo_wr_rst),
        .load     (to_load_s),
        .load_val (TIMEOUT_LD),
        .expired  (to_expired_s)
    );
`endif

    // Next-state decode plus counter load control.
    always_comb begin
        state_nxt_s    = state_r;
        bad_mode_set_s = 1'b0;
        cnt_load_s     = 1'b0;
        cnt_load_val_s = {CNT_W{1'b0}};
`ifdef C3AIBADAPT_RXDP_SEQ_TIMEOUT_EN
        to_load_s      = 1'b0;
        drain_to_set_s = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (!mode_is_valid(cfg_mode_req)) begin
                        // Handshake completes but nothing changes.
                        bad_mode_set_s = 1'b1;
                        state_nxt_s    = ST_IDLE;
                    end else if ((cfg_mode_req == dp_map_mode_r) &&
                                 (cfg_wm_en_req == dp_wm_en_r)) begin
                        // Already committed: acknowledge without disturbing traffic.
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s    = ST_HOLD;
                        cnt_load_s     = 1'b1;
                        cnt_load_val_s = DRAIN_LD;
`ifdef C3AIBADAPT_RXDP_SEQ_TIMEOUT_EN
                        to_load_s      = 1'b1;
`endif
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (cnt_expired_s && fifo_empty) begin
                    state_nxt_s    = ST_RST;
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = RST_LD;
                end
`ifdef C3AIBADAPT_RXDP_SEQ_TIMEOUT_EN
                else if (to_expired_s) begin
                    // Give up on the drain; the capture reset still follows.
                    state_nxt_s    = ST_RST;
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = RST_LD;
                    drain_to_set_s = 1'b1;
                end
`endif
                else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_RST: begin
                if (cnt_expired_s) begin
                    state_nxt_s = ST_SWITCH;
                end else begin
                    state_nxt_s = ST_RST;
                end
            end
            ST_SWITCH: begin
                state_nxt_s    = ST_SETTLE;
                cnt_load_s     = 1'b1;
                cnt_load_val_s = SETTLE_LD;
            end
            ST_SETTLE: begin
                if (cnt_expired_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and outputs; outputs are decoded from the next state so
    // they line up with the state they describe.
    always_ff @(posedge rx_clock_fifo_wr_clk or posedge rx_reset_fifo_wr_rst) begin
        if (rx_reset_fifo_wr_rst) begin
            state_r       <= ST_IDLE;
            dp_wr_hold_r  <= 1'b0;
            dp_path_rst_r <= 1'b0;
            cfg_done_r    <= 1'b0;
            seq_busy_r    <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            dp_wr_hold_r  <= (state_nxt_s == ST_HOLD)   || (state_nxt_s == ST_RST) ||
                             (state_nxt_s == ST_SWITCH) || (state_nxt_s == ST_SETTLE);
            dp_path_rst_r <= (state_nxt_s == ST_RST);
            cfg_done_r    <= (state_nxt_s == ST_DONE);
            seq_busy_r    <= (state_nxt_s != ST_IDLE);
        end
    end

    // Request capture on accept and mode commit in SWITCH.
    always_ff @(posedge rx_clock_fifo_wr_clk or posedge rx_reset_fifo_wr_rst) begin
        if (rx_reset_fifo_wr_rst) begin
            mode_q_r      <= MODE_OFF;
            wm_q_r        <= 1'b0;
            dp_map_mode_r <= MODE_OFF;
            dp_wm_en_r    <= 1'b0;
        end else begin
            if (accept_s) begin
                mode_q_r <= cfg_mode_req;
                wm_q_r   <= cfg_wm_en_req;
            end else begin
                mode_q_r <= mode_q_r;
                wm_q_r   <= wm_q_r;
            end
            if (state_r == ST_SWITCH) begin
                dp_map_mode_r <= mode_q_r;
                dp_wm_en_r    <= wm_q_r;
            end else begin
                dp_map_mode_r <= dp_map_mode_r;
                dp_wm_en_r    <= dp_wm_en_r;
            end
        end
    end

    // Sticky reject flag; a clear in the same cycle wins.
    always_ff @(posedge rx_clock_fifo_wr_clk or posedge rx_reset_fifo_wr_rst) begin
        if (rx_reset_fifo_wr_rst) begin
            err_bad_mode_r <= 1'b0;
        end else if (err_clr) begin
            err_bad_mode_r <= 1'b0;
        end else begin
            err_bad_mode_r <= err_bad_mode_r | bad_mode_set_s;
        end
    end

`ifdef C3AIBADAPT_RXDP_SEQ_TIMEOUT_EN
    // Sticky drain-timeout flag; a clear in the same cycle wins.
    always_ff @(posedge rx_clock_fifo_wr_clk or posedge rx_reset_fifo_wr_rst) begin
        if (rx_reset_fifo_wr_rst) begin
            err_drain_to_r <= 1'b0;
        end else if (err_clr) begin
            err_drain_to_r <= 1'b0;
        end else begin
            err_drain_to_r <= err_drain_to_r | drain_to_set_s;
        end
    end

    assign err_drain_to = err_drain_to_r;
`else
    assign err_drain_to = 1'b0;
`endif

    assign cfg_done     = cfg_done_r;
    assign dp_map_mode  = dp_map_mode_r;
    assign dp_wm_en     = dp_wm_en_r;
    assign dp_wr_hold   = dp_wr_hold_r;
    assign dp_path_rst  = dp_path_rst_r;
    assign seq_busy     = seq_busy_r;
    assign err_bad_mode = err_bad_mode_r;

endmodule
